control_contador_bcd: RTL and testbench
=======================================

Name: control_contador_bcd

Overview:
Run controller for the 3-digit BCD counter (contador_BCD: clk, rst, clk_en, sal[11:0]).
- Generates the counter's clk_en tick from a prescaler and its clear pulse.
- Accepts start/stop/clear commands and watches sal against a BCD limit.
- Either stops at the limit or reloads from 000, flagging completion.
- Sits between the front-panel/command logic and the counter; the counter's sal is fed back.

Parameters:
PRESCALE, 50000, clk cycles per count tick; must be >= 2
PRESC_W, 16, prescaler width; 2**PRESC_W >= PRESCALE
AUTO_RELOAD, 0, 0: stop in DONE at limit; 1: clear counter and keep running

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  command pulse: run/resume
stop  in  1  command pulse: pause
clear  in  1  command pulse: abort and clear
lim  in  12  BCD limit {hundreds,tens,units}, sampled on accepted start from IDLE/DONE
sal  in  12  counter value fed back from contador_BCD
clk_en  out  1  one-cycle count-enable tick to counter
cnt_clr  out  1  one-cycle clear to counter rst
done  out  1  one-cycle pulse on reaching limit
running  out  1  high in RUN
lim_err  out  1  sticky: last start rejected for non-BCD lim; cleared by the next accepted start or clear
estado  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (async): estado=IDLE, prescaler=0, lim_q=000, all outputs 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Command priority in the same cycle: clear > stop > start.
- IDLE, start:
  - If any lim digit > 9: lim_err=1, stay IDLE.
  - Else: latch lim_q, lim_err=0, go RUN.
  - cnt_clr=1 for the first RUN cycle; prescaler=0.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - clk_en=1 exactly on the cycle the prescaler equals PRESCALE-1, giving a tick period of PRESCALE cycles.
  - The first tick occurs PRESCALE cycles after entering RUN.
- RUN, stop: go PAUSE; prescaler holds its value; clk_en=0.
- PAUSE, start: resume RUN from the held prescaler value, no clear, lim_q unchanged.
- PAUSE, stop: ignored.
- Limit compare, sal==lim_q:
  - Evaluated every RUN cycle.
  - Masked while cnt_clr is high and in the cycle immediately after, because sal updates one edge after clear or tick.
- Limit hit, AUTO_RELOAD=0:
  - Next cycle estado=DONE, done=1 for one cycle, clk_en suppressed.
  - sal holds lim_q.
- Limit hit, AUTO_RELOAD=1:
  - done=1 and cnt_clr=1 in the same cycle; stay RUN; prescaler restarts at 0.
- DONE: start behaves as from IDLE (re-latch lim, clear, RUN); stop is ignored.
- clear, any state: next cycle estado=IDLE, cnt_clr=1 one cycle, prescaler=0, lim_err=0.
- lim=000: start → RUN with clear; compare unmasks on the third RUN cycle (no tick yet) → DONE with zero ticks issued.
- Limit 999 with AUTO_RELOAD=1: wraps cleanly; the counter's own 999→000 rollover is never reached.
- Any tick coinciding with a limit hit or stop is suppressed; no tick ever follows done in AUTO_RELOAD=0.
- Mid-run reset: immediate IDLE; the counter is not cleared by this block (the counter shares rst).

Decomposition:
- Package contador_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE} with 2-bit encoding
  - BCD_DIGITS=3, BCD_W=12
  - function bcd_valid(12-bit)
- One natural sub-module: prescaler_tick (PRESCALE, PRESC_W; inputs enable, restart; output tick).
- The FSM and compare stay in the top.

Test Plan:
1. Bench setup: PRESCALE=4, AUTO_RELOAD=0, behavioural contador_BCD attached.
   Start with lim=12'h012 → cnt_clr at RUN cycle 1; clk_en every 4 cycles; exactly 12 ticks; sal=12'h012; done one cycle; estado=3; no further clk_en.
2. lim=12'h0A5, start → lim_err=1, estado stays 0, no cnt_clr.
   Then lim=12'h005, start → lim_err=0, RUN.
3. Pause/resume: run to sal=12'h003, stop mid-prescale (prescaler=2) → PAUSE, clk_en=0 for 20 cycles.
   Start → next tick after 2 more cycles; total ticks unchanged.
4. AUTO_RELOAD=1, lim=12'h002 → done pulses every 2 ticks, each with cnt_clr; sal sequence 000,001,002,000,...; estado stays 1.
5. Start, stop and clear asserted in the same RUN cycle → IDLE, cnt_clr=1; rst asserted mid-RUN → all outputs 0 asynchronously, before the next clk edge.
6. lim=12'h000, start → zero clk_en, done within 4 cycles of start, estado=3.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared types and helpers for the BCD counter run controller.
package contador_pkg;

    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned BCD_W      = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } estado_t;

    // True when every nibble of v is a decimal digit.
    function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/control_contador_bcd_prescaler_tick.sv
// Free-running prescaler; tick_c flags that the next-cycle count is the last one of the period.
module prescaler_tick #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned PRESC_W  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic tick_c
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    // The last count always wraps, so a tick already issued is never repeated after a pause.
    always_comb begin
        cnt_d  = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + PRESC_W'(1);
        end
        tick_c = (cnt_d == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/control_contador_bcd.sv
// Run controller for the 3-digit BCD counter: command FSM, tick generation and limit compare.
module control_contador_bcd
    import contador_pkg::*;
#(
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned PRESC_W     = 16,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [BCD_W-1:0] lim,
    input  logic [BCD_W-1:0] sal,
    output logic             clk_en,
    output logic             cnt_clr,
    output logic             done,
    output logic             running,
    output logic             lim_err,
    output logic [1:0]       estado
);

    estado_t          state_q, state_d;
    logic [BCD_W-1:0] lim_q, lim_d;
    logic             clk_en_q, clk_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             done_q, done_d;
    logic             running_q, running_d;
    logic             lim_err_q, lim_err_d;
    logic             clr_dly_q, clr_dly_d;
    logic             presc_en_c, presc_restart_c, tick_c, hit_c;

    prescaler_tick #(
        .PRESCALE (PRESCALE),
        .PRESC_W  (PRESC_W)
    ) u_presc (
        .clk     (clk),
        .rst     (rst),
        .enable  (presc_en_c),
        .restart (presc_restart_c),
        .tick_c  (tick_c)
    );

    // sal lags a clear by one edge, so the compare ignores the clear cycle and the one after.
    always_comb begin
        state_d         = state_q;
        lim_d           = lim_q;
        lim_err_d       = lim_err_q;
        cnt_clr_d       = 1'b0;
        done_d          = 1'b0;
        presc_en_c      = 1'b0;
        presc_restart_c = 1'b0;
        hit_c           = (state_q == RUN) && !cnt_clr_q && !clr_dly_q && (sal == lim_q);

        if (clear) begin
            state_d         = IDLE;
            cnt_clr_d       = 1'b1;
            presc_restart_c = 1'b1;
            lim_err_d       = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (!stop && start) begin
                        if (bcd_valid(lim)) begin
                            state_d         = RUN;
                            lim_d           = lim;
                            lim_err_d       = 1'b0;
                            cnt_clr_d       = 1'b1;
                            presc_restart_c = 1'b1;
                        end else begin
                            lim_err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (hit_c) begin
                        done_d = 1'b1;
                        if (AUTO_RELOAD) begin
                            cnt_clr_d       = 1'b1;
                            presc_restart_c = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        presc_en_c = 1'b1;
                    end
                end
                PAUSE: begin
                    if (!stop && start) state_d = RUN;
                end
            endcase
        end

        running_d = (state_d == RUN);
        clr_dly_d = cnt_clr_q;
    end

    assign clk_en_d = (state_d == RUN) && tick_c && !cnt_clr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lim_q     <= '0;
            clk_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            lim_err_q <= 1'b0;
            clr_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lim_q     <= lim_d;
            clk_en_q  <= clk_en_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
            running_q <= running_d;
            lim_err_q <= lim_err_d;
            clr_dly_q <= clr_dly_d;
        end
    end

    assign clk_en  = clk_en_q;
    assign cnt_clr = cnt_clr_q;
    assign done    = done_q;
    assign running = running_q;
    assign lim_err = lim_err_q;
    assign estado  = state_q;

endmodule

// File: tb/tb_control_contador_bcd.sv
// Bench for control_contador_bcd with behavioural BCD counters in the loop (PRESCALE=4).
module tb_control_contador_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [11:0] lim = 12'h000;

    logic [11:0] sal_a, sal_b;
    logic        clk_en_a, cnt_clr_a, done_a, running_a, lim_err_a;
    logic        clk_en_b, cnt_clr_b, done_b, running_b, lim_err_b;
    logic [1:0]  estado_a, estado_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_contador_bcd #(.PRESCALE(4), .PRESC_W(4), .AUTO_RELOAD(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .lim(lim), .sal(sal_a), .clk_en(clk_en_a), .cnt_clr(cnt_clr_a),
        .done(done_a), .running(running_a), .lim_err(lim_err_a), .estado(estado_a)
    );

    control_contador_bcd #(.PRESCALE(4), .PRESC_W(4), .AUTO_RELOAD(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .lim(lim), .sal(sal_b), .clk_en(clk_en_b), .cnt_clr(cnt_clr_b),
        .done(done_b), .running(running_b), .lim_err(lim_err_b), .estado(estado_b)
    );

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Counter models: shared async rst, synchronous clear from cnt_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            sal_a <= 12'h000;
        else if (cnt_clr_a) sal_a <= 12'h000;
        else if (clk_en_a)  sal_a <= bcd_inc(sal_a);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            sal_b <= 12'h000;
        else if (cnt_clr_b) sal_b <= 12'h000;
        else if (clk_en_b)  sal_b <= bcd_inc(sal_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go(input logic [11:0] l);
        @(negedge clk);
        lim   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct packed {
        logic       st, sp, cl;
        logic [11:0] lim;
        logic [1:0] e_est;
        logic       e_en, e_clr, e_done, e_run, e_err;
    } vec_t;

    function automatic vec_t mk(input logic st, sp, cl, input logic [11:0] l, input logic [1:0] est,
                                input logic en, clr, dn, run, err);
        vec_t v;
        v.st = st; v.sp = sp; v.cl = cl; v.lim = l; v.e_est = est;
        v.e_en = en; v.e_clr = clr; v.e_done = dn; v.e_run = run; v.e_err = err;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t vecs[20];
        int   cyc, ticks, first, last, gap_bad, extra, dones, clr_bad, est_bad;
        logic [11:0] prev;
        logic [11:0] seq[$];

        //                st    sp    cl    lim      est   en    clr   done  run   err
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 12'h0A5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 12'h0A5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 12'h005, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 12'h005, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 12'h005, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 12'h005, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 12'h005, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 12'h005, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 12'h005, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 12'h005, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 12'h000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 12'h000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 12'h000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 12'h000, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 12'h000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 12'h000, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(1'b1, 1'b0, 1'b0, 12'h0F0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 1'b1, 12'h0F0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 12'h0F0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        #1;
        chk("in_reset", 32'({estado_a, clk_en_a, cnt_clr_a, done_a, running_a, lim_err_a}), 32'h0);
        do_reset();

        // Single-cycle command vectors: lim_err, clear priority, lim=000, DONE handling.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = vecs[i].st;
            stop  = vecs[i].sp;
            clear = vecs[i].cl;
            lim   = vecs[i].lim;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                32'({estado_a, clk_en_a, cnt_clr_a, done_a, running_a, lim_err_a}),
                32'({vecs[i].e_est, vecs[i].e_en, vecs[i].e_clr, vecs[i].e_done,
                     vecs[i].e_run, vecs[i].e_err}));
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0;

        // Full run to limit 012.
        do_reset();
        go(12'h012);
        cyc = 1; ticks = 0; first = 0; last = 0; gap_bad = 0;
        chk("t1_clr_first", 32'(cnt_clr_a), 32'd1);
        while (!done_a && cyc < 200) begin
            if (clk_en_a) begin
                ticks++;
                if (ticks == 1) first = cyc;
                else if (cyc - last != 4) gap_bad++;
                last = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        chk("t1_done_seen", 32'(done_a), 32'd1);
        chk("t1_done_cycle", 32'(cyc), 32'd50);
        chk("t1_ticks", 32'(ticks), 32'd12);
        chk("t1_first_tick", 32'(first), 32'd4);
        chk("t1_tick_gaps", 32'(gap_bad), 32'd0);
        chk("t1_sal", 32'(sal_a), 32'h012);
        chk("t1_estado", 32'(estado_a), 32'd3);
        chk("t1_done_en", 32'(clk_en_a), 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done_a), 32'd0);
        extra = 0;
        repeat (10) begin
            if (clk_en_a || done_a) extra++;
            @(negedge clk);
        end
        chk("t1_quiet_after", 32'(extra), 32'd0);

        // Pause with prescaler at 2, then resume.
        do_reset();
        go(12'h005);
        cyc = 1; ticks = 0;
        while (sal_a != 12'h003 && cyc < 100) begin
            if (clk_en_a) ticks++;
            @(negedge clk);
            cyc++;
        end
        chk("t3_sal3_cycle", 32'(cyc), 32'd13);
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t3_pause", 32'(estado_a), 32'd2);
        extra = 0;
        repeat (20) begin
            if (clk_en_a || estado_a != 2'd2) extra++;
            @(negedge clk);
        end
        chk("t3_paused_quiet", 32'(extra), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t3_resume_state", 32'({estado_a, clk_en_a, cnt_clr_a}), 32'({2'd1, 1'b0, 1'b0}));
        @(negedge clk);
        chk("t3_resume_tick", 32'(clk_en_a), 32'd1);
        cyc = 0;
        while (!done_a && cyc < 100) begin
            if (clk_en_a) ticks++;
            @(negedge clk);
            cyc++;
        end
        chk("t3_done_seen", 32'(done_a), 32'd1);
        chk("t3_total_ticks", 32'(ticks), 32'd5);
        chk("t3_sal", 32'(sal_a), 32'h005);

        // Auto-reload with limit 002 on the second instance.
        do_reset();
        go(12'h002);
        dones = 0; clr_bad = 0; est_bad = 0;
        prev = sal_b;
        seq.delete();
        repeat (40) begin
            if (done_b) begin
                dones++;
                if (!cnt_clr_b) clr_bad++;
            end
            if (estado_b != 2'd1) est_bad++;
            if (sal_b != prev) begin
                seq.push_back(sal_b);
                prev = sal_b;
            end
            @(negedge clk);
        end
        chk("t4_dones", 32'(dones), 32'd4);
        chk("t4_done_with_clr", 32'(clr_bad), 32'd0);
        chk("t4_stay_run", 32'(est_bad), 32'd0);
        chk("t4_seq_len", 32'(seq.size() >= 6), 32'd1);
        if (seq.size() >= 6) begin
            chk("t4_seq", 32'({seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0], seq[4][3:0], seq[5][3:0]}),
                32'h120120);
        end

        // Asynchronous reset in the middle of a run.
        do_reset();
        go(12'h012);
        chk("t5_pre_rst", 32'({estado_a, cnt_clr_a, running_a}), 32'({2'd1, 1'b1, 1'b1}));
        rst = 1'b1;
        #1;
        chk("t5_async_rst", 32'({estado_a, clk_en_a, cnt_clr_a, done_a, running_a, lim_err_a}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
